// File: rtl/sseg_disp_mux_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display driver.
// All patterns are active low: a set bit turns a segment or an anode off.
package sseg_disp_mux_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] AN_OFF     = 4'hF;
  localparam logic [7:0] SSEG_OFF   = 8'hFF;

  // Active-low one-cold anode pattern for the selected digit.
  function automatic logic [3:0] an_select(input logic [1:0] idx);
    an_select = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sseg_refresh_timer.sv
// Slot/frame timing for the display multiplexer: slot counter, digit index,
// frame boundary strobe and the per-cycle "digit is lit" decision.
module sseg_refresh_timer
  import sseg_disp_mux_pkg::*;
#(
  parameter int DIG_CNT_W = 16,
  parameter int BLANK_CYC = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] bright,
  output logic [1:0] idx,
  output logic       frame_tk,
  output logic       lit
);

  localparam logic [DIG_CNT_W-1:0] BLANK_VAL = DIG_CNT_W'(BLANK_CYC);

  logic [DIG_CNT_W-1:0] cnt;
  logic                 cnt_wrap;

  assign cnt_wrap = (cnt == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt_wrap)
        idx <= idx + 2'd1;
    end
  end

  assign frame_tk = cnt_wrap && (idx == 2'd3);

  // Leading blank window keeps adjacent anodes from overlapping; the top four
  // counter bits set the duty cycle in sixteenths of a slot.
  assign lit = en && (cnt >= BLANK_VAL) && (cnt[DIG_CNT_W-1 -: 4] <= bright);

endmodule

// File: rtl/sseg_disp_mux.sv
// Four-digit seven-segment multiplexer with frame-synchronous pattern update,
// ghost blanking between digits and 16-level brightness.
module sseg_disp_mux
  import sseg_disp_mux_pkg::*;
#(
  parameter int DIG_CNT_W = 16,
  parameter int BLANK_CYC = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic       load,
  input  logic [3:0] bright,
  input  logic       en,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tk
);

  logic [1:0] idx;
  logic       lit;
  logic       pend;
  logic [7:0] in_vec [NUM_DIGITS];
  logic [7:0] stage  [NUM_DIGITS];
  logic [7:0] disp   [NUM_DIGITS];

  assign in_vec[0] = in0;
  assign in_vec[1] = in1;
  assign in_vec[2] = in2;
  assign in_vec[3] = in3;

  sseg_refresh_timer #(
    .DIG_CNT_W (DIG_CNT_W),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .bright   (bright),
    .idx      (idx),
    .frame_tk (frame_tk),
    .lit      (lit)
  );

  // Patterns land in stage at any time; disp only changes on the frame
  // boundary, with a load on that very cycle bypassing stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        stage[i] <= SSEG_OFF;
        disp[i]  <= SSEG_OFF;
      end
    end else begin
      if (load) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          stage[i] <= in_vec[i];
      end
      if (frame_tk) begin
        pend <= 1'b0;
        if (load) begin
          for (int i = 0; i < NUM_DIGITS; i++)
            disp[i] <= in_vec[i];
        end else if (pend) begin
          for (int i = 0; i < NUM_DIGITS; i++)
            disp[i] <= stage[i];
        end
      end else if (load) begin
        pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an   <= AN_OFF;
      sseg <= SSEG_OFF;
    end else if (lit) begin
      an   <= an_select(idx);
      sseg <= disp[idx];
    end else begin
      an   <= AN_OFF;
      sseg <= SSEG_OFF;
    end
  end

endmodule

// File: tb/tb_sseg_disp_mux.sv
// Bench for sseg_disp_mux: frame-position model checked every cycle, plus
// directed scenarios with literal expectations at known frame positions.
module tb_sseg_disp_mux;

  localparam int W     = 6;
  localparam int BLANK = 2;
  localparam int SLOT  = 1 << W;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] in0 = 8'hFF, in1 = 8'hFF, in2 = 8'hFF, in3 = 8'hFF;
  logic       load = 1'b0;
  logic [3:0] bright = 4'd15;
  logic       en = 1'b0;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tk;

  int n_chk = 0;
  int n_fail = 0;

  sseg_disp_mux #(.DIG_CNT_W(W), .BLANK_CYC(BLANK)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .load     (load),
    .bright   (bright),
    .en       (en),
    .an       (an),
    .sseg     (sseg),
    .frame_tk (frame_tk)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position in frame since reset, what the display shows this frame,
  // and the most recent pattern loaded but not yet shown.
  int         pos = 0;
  logic [7:0] shown  [4];
  logic [7:0] latest [4];
  bit         fresh = 0;
  logic [3:0] exp_an = 4'hF;
  logic [7:0] exp_sseg = 8'hFF;
  bit         exp_ftk = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos = 0;
      fresh = 0;
      exp_an = 4'hF;
      exp_sseg = 8'hFF;
      for (int i = 0; i < 4; i++) begin
        shown[i] = 8'hFF;
        latest[i] = 8'hFF;
      end
    end else begin
      int  c, d;
      bit  on;
      c = pos % SLOT;
      d = pos / SLOT;
      on = en && (c >= BLANK) && ((c / (SLOT / 16)) <= int'(bright));
      exp_an = 4'hF;
      exp_sseg = 8'hFF;
      if (on) begin
        exp_an[d] = 1'b0;
        exp_sseg = shown[d];
      end
      if (load) begin
        latest[0] = in0; latest[1] = in1; latest[2] = in2; latest[3] = in3;
      end
      if (pos == FRAME - 1) begin
        if (load || fresh)
          for (int i = 0; i < 4; i++) shown[i] = latest[i];
        fresh = 0;
      end else if (load) begin
        fresh = 1;
      end
      pos = (pos + 1) % FRAME;
    end
    exp_ftk = (pos == FRAME - 1);
  end

  always @(negedge clk) begin
    check("an", an, exp_an);
    check("sseg", sseg, exp_sseg);
    check("frame_tk", frame_tk, exp_ftk);
    check("an_one_cold", $countones(~an) <= 1, 1);
  end

  task automatic wait_ftk(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tk && n < FRAME + 50);
    if (!frame_tk) begin
      n_chk++;
      n_fail++;
      $display("FAIL ftk_timeout: no frame_tk after %0d cycles", n);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load;
    @(posedge clk); #1;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  initial begin
    int n;
    #2 reset_n = 1'b0;
    #1;
    check("rst_an", an, 4'hF);
    check("rst_sseg", sseg, 8'hFF);
    check("rst_ftk", frame_tk, 0);
    skip(3);
    reset_n = 1'b1;

    // Load four patterns; nothing visible until the next frame begins.
    @(posedge clk); #1;
    en = 1'b1; bright = 4'd15;
    in0 = 8'h81; in1 = 8'hCF; in2 = 8'h92; in3 = 8'h86;
    pulse_load();
    skip(3);
    check("pre_frame_sseg", sseg, 8'hFF);
    wait_ftk(n);
    skip(3);
    check("slot0_blank_an", an, 4'hF);
    skip(1);
    check("slot0_an", an, 4'b1110);
    check("slot0_sseg", sseg, 8'h81);
    skip(192);
    check("slot3_an", an, 4'b0111);
    check("slot3_sseg", sseg, 8'h86);

    // Dimming: bright=0 lights cnt 2..3, bright=7 lights cnt 2..31.
    @(posedge clk); #1;
    bright = 4'd0;
    wait_ftk(n);
    skip(5);
    check("b0_cnt3_an", an, 4'b1110);
    skip(1);
    check("b0_cnt4_an", an, 4'hF);
    @(posedge clk); #1;
    bright = 4'd7;
    wait_ftk(n);
    skip(33);
    check("b7_cnt31_an", an, 4'b1110);
    skip(1);
    check("b7_cnt32_an", an, 4'hF);
    @(posedge clk); #1;
    bright = 4'd15;

    // Load on the boundary cycle bypasses staging.
    wait_ftk(n);
    load = 1'b1;
    in0 = 8'h00;
    @(posedge clk); #1;
    load = 1'b0;
    skip(4);
    check("bypass_an", an, 4'b1110);
    check("bypass_sseg", sseg, 8'h00);

    // Two loads in one frame: the last one wins.
    in0 = 8'h24;
    pulse_load();
    skip(10);
    in0 = 8'hA0;
    pulse_load();
    wait_ftk(n);
    skip(4);
    check("lastwin_sseg", sseg, 8'hA0);

    // Mid-frame reset while lit, with a load still pending.
    in0 = 8'h55;
    pulse_load();
    skip(2);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("midrst_an", an, 4'hF);
    check("midrst_sseg", sseg, 8'hFF);
    check("midrst_ftk", frame_tk, 0);
    skip(3);
    reset_n = 1'b1;
    wait_ftk(n);
    check("first_ftk_delay", n, FRAME - 1);
    skip(4);
    check("discard_an", an, 4'b1110);
    check("discard_sseg", sseg, 8'hFF);

    // Display disabled: dark for a whole frame, frame ticks keep coming.
    @(posedge clk); #1;
    en = 1'b0;
    wait_ftk(n);
    wait_ftk(n);
    check("en0_period", n, FRAME);
    check("en0_an", an, 4'hF);
    skip(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
